// File: rtl/baud_rate_scheduler.sv
// Baud-rate period scheduler: steps through a fixed 8-entry bit-period table,
// with optional auto-baud measurement compiled in by BAUD_RATE_SCHEDULER_AUTO_BAUD_EN.
module baud_rate_scheduler #(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int DEFAULT_INDEX = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Next,
  input  logic        i_Default,
  input  logic        i_Auto_Start,
  input  logic        i_UART_RX,
  output logic [19:0] o_Period,
  output logic [2:0]  o_Index,
  output logic        o_Busy,
  output logic        o_Auto_Done,
  output logic        o_Auto_Fail
);

  localparam logic [2:0] DEFAULT_IDX = 3'(DEFAULT_INDEX);

  function automatic logic [19:0] period_of(input logic [2:0] idx);
    int rate;
    case (idx)
      3'd0:    rate = 9600;
      3'd1:    rate = 19200;
      3'd2:    rate = 38400;
      3'd3:    rate = 57600;
      3'd4:    rate = 115200;
      3'd5:    rate = 230400;
      3'd6:    rate = 460800;
      default: rate = 921600;
    endcase
    return 20'(CLK_FREQ / rate);
  endfunction

  logic [2:0] index_next;

  // NOTE: async reset in the sensitivity list and <= for every flop, so all
  // registers update together from pre-edge values.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Index  <= DEFAULT_IDX;
      o_Period <= period_of(DEFAULT_IDX);
    end else begin
      o_Index  <= index_next;
      o_Period <= period_of(o_Index);
    end
  end

`ifdef BAUD_RATE_SCHEDULER_AUTO_BAUD_EN

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, SCAN} state_t;

  localparam int          P0      = CLK_FREQ / 9600;
  localparam logic [12:0] M_LIMIT = 13'(2 * P0);

  state_t      state, state_next;
  logic        rx_meta, rx_sync, rx_prev;
  logic        rx_fall, rx_rise;
  logic [12:0] m, m_next;
  logic [2:0]  scan_idx, scan_idx_next;
  logic        found, found_next;
  logic [2:0]  found_idx, found_idx_next;
  logic        done_next, fail_next;
  logic [19:0] scan_period, m_ext, scan_diff;
  logic        scan_match;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      m           <= '0;
      scan_idx    <= '0;
      found       <= 1'b0;
      found_idx   <= '0;
      o_Auto_Done <= 1'b0;
      o_Auto_Fail <= 1'b0;
    end else begin
      rx_meta     <= i_UART_RX;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      state       <= state_next;
      m           <= m_next;
      scan_idx    <= scan_idx_next;
      found       <= found_next;
      found_idx   <= found_idx_next;
      o_Auto_Done <= done_next;
      o_Auto_Fail <= fail_next;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_rise = ~rx_prev & rx_sync;

  // One table entry is compared against the measured width per SCAN cycle.
  assign scan_period = period_of(scan_idx);
  assign m_ext       = {7'd0, m};
  assign scan_diff   = (m_ext >= scan_period) ? (m_ext - scan_period) : (scan_period - m_ext);
  assign scan_match  = (scan_diff <= (scan_period >> 3));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    index_next     = o_Index;
    m_next         = m;
    scan_idx_next  = scan_idx;
    found_next     = found;
    found_idx_next = found_idx;
    done_next      = 1'b0;
    fail_next      = 1'b0;
    if (i_Default) begin
      state_next = IDLE;
      index_next = DEFAULT_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (i_Next)            index_next = o_Index + 3'd1;
          else if (i_Auto_Start) state_next = ARMED;
        end
        ARMED: begin
          if (rx_fall) begin
            state_next = MEASURE;
            m_next     = 13'd1;
          end
        end
        MEASURE: begin
          if (rx_rise) begin
            state_next    = SCAN;
            scan_idx_next = 3'd0;
            found_next    = 1'b0;
          end else if (m >= M_LIMIT) begin
            state_next = IDLE;
            fail_next  = 1'b1;
          end else if (!rx_sync && (m != '1)) begin
            m_next = m + 13'd1;
          end
        end
        SCAN: begin
          scan_idx_next = scan_idx + 3'd1;
          if (scan_match && !found) begin
            found_next     = 1'b1;
            found_idx_next = scan_idx;
          end
          if (scan_idx == 3'd7) begin
            state_next = IDLE;
            if (found) begin
              index_next = found_idx;
              done_next  = 1'b1;
            end else if (scan_match) begin
              index_next = scan_idx;
              done_next  = 1'b1;
            end else begin
              fail_next = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign o_Busy = (state != IDLE);

`else

  logic unused_inputs;
  assign unused_inputs = ^{i_Auto_Start, i_UART_RX};

  always_comb begin
    index_next = o_Index;
    if (i_Default)   index_next = DEFAULT_IDX;
    else if (i_Next) index_next = o_Index + 3'd1;
  end

  assign o_Busy      = 1'b0;
  assign o_Auto_Done = 1'b0;
  assign o_Auto_Fail = 1'b0;

`endif

endmodule

// File: tb/tb_baud_rate_scheduler.sv
// Directed bench for baud_rate_scheduler; auto-baud cases run only when
// BAUD_RATE_SCHEDULER_AUTO_BAUD_EN is defined, otherwise the disabled behaviour is checked.
module tb_baud_rate_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        next_p, default_p, auto_start, uart_rx;
  logic [19:0] period;
  logic [2:0]  index;
  logic        busy, auto_done, auto_fail;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int fail_cnt = 0;
  int busy_cnt = 0;

  baud_rate_scheduler #(.CLK_FREQ(25_000_000), .DEFAULT_INDEX(4)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Next      (next_p),
    .i_Default   (default_p),
    .i_Auto_Start(auto_start),
    .i_UART_RX   (uart_rx),
    .o_Period    (period),
    .o_Index     (index),
    .o_Busy      (busy),
    .o_Auto_Done (auto_done),
    .o_Auto_Fail (auto_fail)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (auto_done) done_cnt++;
    if (auto_fail) fail_cnt++;
    if (busy)      busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    next_p = 1'b1;
    tick();
    next_p = 1'b0;
  endtask

  task automatic rx_low(input int n);
    uart_rx = 1'b0;
    repeat (n) tick();
    uart_rx = 1'b1;
  endtask

  // Waits for a done/fail pulse; on timeout both flags are left 0.
  task automatic wait_result(input int limit, output logic done_seen, output logic fail_seen);
    done_seen = 1'b0;
    fail_seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (auto_done || auto_fail) begin
        done_seen = auto_done;
        fail_seen = auto_fail;
        break;
      end
    end
  endtask

  logic [2:0]  exp_idx [9] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [19:0] exp_per [9] = '{20'd108, 20'd54, 20'd27, 20'd2604, 20'd1302,
                               20'd651, 20'd434, 20'd217, 20'd108};

  initial begin
    logic d, f;
    int   dc, fc;
    rst = 1'b1; next_p = 1'b0; default_p = 1'b0; auto_start = 1'b0; uart_rx = 1'b1;
    repeat (3) tick();
    check("rst_index", index, 4);
    check("rst_period", period, 217);
    check("rst_busy", busy, 0);
    check("rst_done", auto_done, 0);
    check("rst_fail", auto_fail, 0);
    rst = 1'b0;
    tick();
    check("post_rst_index", index, 4);
    check("post_rst_period", period, 217);

    // Nine steps through the table, wrapping 7 -> 0
    for (int i = 0; i < 9; i++) begin
      pulse_next();
      check($sformatf("next_index_%0d", i), index, exp_idx[i]);
      tick();
      check($sformatf("next_period_%0d", i), period, exp_per[i]);
      repeat (2) tick();
    end

    // i_Default returns to index 4
    default_p = 1'b1;
    tick();
    default_p = 1'b0;
    check("default_index", index, 4);
    tick();
    check("default_period", period, 217);

    // i_Next outranks i_Auto_Start
    next_p = 1'b1; auto_start = 1'b1;
    tick();
    next_p = 1'b0; auto_start = 1'b0;
    check("prio_next_index", index, 5);
    check("prio_next_busy", busy, 0);
    default_p = 1'b1;
    tick();
    default_p = 1'b0;

`ifdef BAUD_RATE_SCHEDULER_AUTO_BAUD_EN
    // 434-cycle low pulse locks to index 3
    auto_start = 1'b1;
    tick();
    auto_start = 1'b0;
    check("armed_busy", busy, 1);
    pulse_next();
    check("armed_ignores_next", index, 4);
    rx_low(434);
    wait_result(40, d, f);
    check("lock434_done", d, 1);
    check("lock434_fail", f, 0);
    check("lock434_index", index, 3);
    tick();
    check("lock434_period", period, 434);
    check("lock434_done_one_cycle", auto_done, 0);
    check("lock434_idle", busy, 0);

    // 300-cycle low pulse matches no entry
    auto_start = 1'b1;
    tick();
    auto_start = 1'b0;
    rx_low(300);
    wait_result(40, d, f);
    check("nomatch_fail", f, 1);
    check("nomatch_done", d, 0);
    check("nomatch_index", index, 3);
    tick();
    check("nomatch_busy", busy, 0);

    // RX held low until the measurement times out
    auto_start = 1'b1;
    tick();
    auto_start = 1'b0;
    uart_rx = 1'b0;
    wait_result(6000, d, f);
    check("timeout_fail", f, 1);
    check("timeout_index", index, 3);
    uart_rx = 1'b1;
    repeat (4) tick();

    // i_Default and i_Next together mid-MEASURE: abort, index 4, no pulses
    dc = done_cnt; fc = fail_cnt;
    auto_start = 1'b1;
    tick();
    auto_start = 1'b0;
    uart_rx = 1'b0;
    repeat (100) tick();
    default_p = 1'b1; next_p = 1'b1;
    tick();
    default_p = 1'b0; next_p = 1'b0;
    check("abort_index", index, 4);
    check("abort_busy", busy, 0);
    uart_rx = 1'b1;
    repeat (30) tick();
    check("abort_no_done", done_cnt - dc, 0);
    check("abort_no_fail", fail_cnt - fc, 0);

    // Reset mid-MEASURE
    pulse_next();
    check("pre_rst_index", index, 5);
    tick();
    dc = done_cnt; fc = fail_cnt;
    auto_start = 1'b1;
    tick();
    auto_start = 1'b0;
    uart_rx = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    #2;
    check("midrst_index", index, 4);
    check("midrst_period", period, 217);
    check("midrst_busy", busy, 0);
    check("midrst_done", auto_done, 0);
    check("midrst_fail", auto_fail, 0);
    tick();
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (30) tick();
    check("midrst_no_done", done_cnt - dc, 0);
    check("midrst_no_fail", fail_cnt - fc, 0);
    check("midrst_idle", busy, 0);
`else
    // Auto-baud compiled out: start pulses and RX activity change nothing
    busy_cnt = 0;
    auto_start = 1'b1;
    tick();
    auto_start = 1'b0;
    rx_low(434);
    repeat (30) tick();
    check("noauto_busy_never", busy_cnt, 0);
    check("noauto_no_done", done_cnt, 0);
    check("noauto_no_fail", fail_cnt, 0);
    check("noauto_index", index, 4);
    check("noauto_period", period, 217);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
